// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding and port constants for the ROM port arbiter.
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
  localparam int PORT_FETCH = 0;
  localparam int PORT_DATA = 1;
  localparam int NUM_PORTS = 2;
  localparam int CNT_W = 3;
endpackage

// File: rtl/rr_pick_2.sv
// rr_pick_2: two-way round-robin selector; on contention the port other than last wins.
module rr_pick_2
  import mem_arb_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 last,
  output logic [NUM_PORTS-1:0] win
);
  always_comb win = &req ? (last ? 2'b01 : 2'b10) : req;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the genrom read port between fetch and data requesters,
// sequencing one transaction at a time through the ROM read latency.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_ADDR  = 4,
  parameter int MEM_EXTRA = 4,
  parameter int ROM_LAT   = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_PORTS-1:0]          req,
  input  logic [MEM_ADDR:0]             addr0,
  input  logic [MEM_ADDR:0]             addr1,
  input  logic [MEM_EXTRA-1:0]          extra0,
  input  logic [MEM_EXTRA-1:0]          extra1,
  input  logic [MEM_ADDR:0]             code_lo,
  input  logic [MEM_ADDR:0]             code_hi,
  input  logic [MEM_ADDR:0]             data_lo,
  input  logic [MEM_ADDR:0]             data_hi,
  output logic [NUM_PORTS-1:0]          gnt,
  output logic [NUM_PORTS-1:0]          rvalid,
  output logic [(2**MEM_EXTRA)*8-1:0]   rdata,
  output logic                          rerror,
  output logic [MEM_ADDR:0]             mem_addr,
  output logic [MEM_EXTRA-1:0]          mem_extra,
  output logic [MEM_ADDR:0]             rom_lower_bound,
  output logic [MEM_ADDR:0]             rom_upper_bound,
  input  logic [(2**MEM_EXTRA)*8-1:0]   mem_data,
  input  logic                          mem_error,
  output logic                          busy
);
  localparam int DW = (2**MEM_EXTRA)*8;
  state_e               state_q, state_d;
  logic                 last_q, last_d, win_q, win_d;
  logic [MEM_ADDR:0]    addr_q, addr_d, lo_q, lo_d, hi_q, hi_d;
  logic [MEM_EXTRA-1:0] extra_q, extra_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DW-1:0]        rdata_q, rdata_d;
  logic                 rerror_q, rerror_d;
  logic [NUM_PORTS-1:0] pick;
  logic                 take, win_idx, last_beat;
  rr_pick_2 u_pick (.req(req), .last(last_q), .win(pick));
  // A grant is possible in IDLE and in the RESP cycle, never while waiting on the ROM.
  assign take      = (state_q != WAIT) && |req && !reset;
  assign win_idx   = pick[PORT_DATA];
  assign last_beat = (state_q == WAIT) && (cnt_q == CNT_W'(1));
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = take ? WAIT : IDLE;
    if (state_q == WAIT) state_d = last_beat ? RESP : WAIT;
  end
  always_comb begin
    gnt             = take ? pick : '0;
    rvalid          = (state_q == RESP) ? (win_q ? 2'b10 : 2'b01) : '0;
    mem_addr        = (state_q == WAIT) ? addr_q : '0;
    mem_extra       = (state_q == WAIT) ? extra_q : '0;
    rom_lower_bound = (state_q == WAIT) ? lo_q : '0;
    rom_upper_bound = (state_q == WAIT) ? hi_q : '0;
    busy            = state_q != IDLE;
  end
  assign rdata  = rdata_q;
  assign rerror = rerror_q;
  always_comb begin
    win_d    = take ? win_idx : win_q;
    last_d   = take ? win_idx : last_q;
    addr_d   = take ? (win_idx ? addr1 : addr0) : addr_q;
    extra_d  = take ? (win_idx ? extra1 : extra0) : extra_q;
    lo_d     = take ? (win_idx ? data_lo : code_lo) : lo_q;
    hi_d     = take ? (win_idx ? data_hi : code_hi) : hi_q;
    cnt_d    = take ? CNT_W'(ROM_LAT) : (state_q == WAIT) ? cnt_q - CNT_W'(1) : cnt_q;
    rdata_d  = last_beat ? mem_data : rdata_q;
    rerror_d = last_beat ? mem_error : rerror_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q   <= 1'b1;
      win_q    <= 1'b0;
      addr_q   <= '0;
      extra_q  <= '0;
      lo_q     <= '0;
      hi_q     <= '0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      rerror_q <= 1'b0;
    end else begin
      last_q   <= last_d;
      win_q    <= win_d;
      addr_q   <= addr_d;
      extra_q  <= extra_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      rerror_q <= rerror_d;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: vector table, directed corner sequences and a randomized
// run against a cycle-count reference model, on ROM_LAT=1 and ROM_LAT=3 instances.
module tb_mem_port_arbiter;
  logic         clk = 0, reset = 1;
  logic [1:0]   req = 0;
  logic [4:0]   addr0 = 0, addr1 = 0, code_lo = 0, code_hi = 31, data_lo = 0, data_hi = 31;
  logic [3:0]   extra0 = 0, extra1 = 0;
  logic [1:0]   gnt1, rvalid1, gnt3, rvalid3;
  logic [127:0] rdata1, rdata3, mdata1, mdata3;
  logic         rerror1, rerror3, merr1, merr3, busy1, busy3;
  logic [4:0]   maddr1, maddr3, rlo1, rhi1, rlo3, rhi3;
  logic [3:0]   mextra1, mextra3;
  int checks = 0, passes = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MEM_ADDR(4), .MEM_EXTRA(4), .ROM_LAT(1)) dut1 (
    .clk(clk), .reset(reset), .req(req), .addr0(addr0), .addr1(addr1),
    .extra0(extra0), .extra1(extra1), .code_lo(code_lo), .code_hi(code_hi),
    .data_lo(data_lo), .data_hi(data_hi), .gnt(gnt1), .rvalid(rvalid1),
    .rdata(rdata1), .rerror(rerror1), .mem_addr(maddr1), .mem_extra(mextra1),
    .rom_lower_bound(rlo1), .rom_upper_bound(rhi1), .mem_data(mdata1),
    .mem_error(merr1), .busy(busy1));

  mem_port_arbiter #(.MEM_ADDR(4), .MEM_EXTRA(4), .ROM_LAT(3)) dut3 (
    .clk(clk), .reset(reset), .req(req), .addr0(addr0), .addr1(addr1),
    .extra0(extra0), .extra1(extra1), .code_lo(code_lo), .code_hi(code_hi),
    .data_lo(data_lo), .data_hi(data_hi), .gnt(gnt3), .rvalid(rvalid3),
    .rdata(rdata3), .rerror(rerror3), .mem_addr(maddr3), .mem_extra(mextra3),
    .rom_lower_bound(rlo3), .rom_upper_bound(rhi3), .mem_data(mdata3),
    .mem_error(merr3), .busy(busy3));

  // ROM contents: byte at address i is 0x41+i; bytes beyond extra read as zero.
  function automatic logic [127:0] rom_read(logic [4:0] a, logic [3:0] x);
    logic [127:0] d = '0;
    for (int i = 0; i < 16; i++)
      if (i <= int'(x)) d[i*8 +: 8] = 8'(int'(a) + i + 'h41);
    return d;
  endfunction

  function automatic logic rom_err(logic [4:0] a, logic [3:0] x, logic [4:0] lo, logic [4:0] hi);
    return (a < lo) || (int'(a) + int'(x) > int'(hi));
  endfunction

  always_comb begin
    mdata1 = rom_read(maddr1, mextra1);
    merr1  = rom_err(maddr1, mextra1, rlo1, rhi1);
    mdata3 = rom_read(maddr3, mextra3);
    merr3  = rom_err(maddr3, mextra3, rlo3, rhi3);
  end

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic cyc_start();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [1:0] req;
    logic [4:0] a0, a1;
    logic [1:0] gnt, rv;
    logic [7:0] byt;
    logic       busy;
    int         maddr;
  } vec_t;
  vec_t v[$];

  logic       last_m, pend, pend_port;
  int         pend_cyc, gnt_cyc, resp_cyc, w;
  logic [127:0] pend_data;
  logic       pend_err;
  logic [1:0] exp_g, exp_rv;

  initial begin
    // contention right after reset: 01,10,01,10
    v.push_back(vec_t'{2'b11, 5'd2, 5'd5, 2'b01, 2'b00, 8'h00, 1'b0, 0});
    v.push_back(vec_t'{2'b11, 5'd2, 5'd5, 2'b00, 2'b00, 8'h00, 1'b1, 2});
    v.push_back(vec_t'{2'b11, 5'd2, 5'd5, 2'b10, 2'b01, 8'h43, 1'b1, -1});
    v.push_back(vec_t'{2'b11, 5'd2, 5'd5, 2'b00, 2'b00, 8'h00, 1'b1, 5});
    v.push_back(vec_t'{2'b11, 5'd2, 5'd5, 2'b01, 2'b10, 8'h46, 1'b1, -1});
    v.push_back(vec_t'{2'b11, 5'd2, 5'd5, 2'b00, 2'b00, 8'h00, 1'b1, 2});
    v.push_back(vec_t'{2'b11, 5'd2, 5'd5, 2'b10, 2'b01, 8'h43, 1'b1, -1});
    v.push_back(vec_t'{2'b00, 5'd2, 5'd5, 2'b00, 2'b00, 8'h00, 1'b1, 5});
    v.push_back(vec_t'{2'b00, 5'd2, 5'd5, 2'b00, 2'b10, 8'h46, 1'b1, 0});
    v.push_back(vec_t'{2'b00, 5'd2, 5'd5, 2'b00, 2'b00, 8'h00, 1'b0, 0});
    // single fetch of byte 0
    v.push_back(vec_t'{2'b01, 5'd0, 5'd0, 2'b01, 2'b00, 8'h00, 1'b0, 0});
    v.push_back(vec_t'{2'b00, 5'd0, 5'd0, 2'b00, 2'b00, 8'h00, 1'b1, 0});
    v.push_back(vec_t'{2'b00, 5'd0, 5'd0, 2'b00, 2'b01, 8'h41, 1'b1, 0});
    v.push_back(vec_t'{2'b00, 5'd0, 5'd0, 2'b00, 2'b00, 8'h00, 1'b0, 0});
    // back-to-back on port 0
    v.push_back(vec_t'{2'b01, 5'd1, 5'd0, 2'b01, 2'b00, 8'h00, 1'b0, 0});
    v.push_back(vec_t'{2'b01, 5'd1, 5'd0, 2'b00, 2'b00, 8'h00, 1'b1, 1});
    v.push_back(vec_t'{2'b01, 5'd1, 5'd0, 2'b01, 2'b01, 8'h42, 1'b1, -1});
    v.push_back(vec_t'{2'b01, 5'd1, 5'd0, 2'b00, 2'b00, 8'h00, 1'b1, 1});
    v.push_back(vec_t'{2'b01, 5'd1, 5'd0, 2'b01, 2'b01, 8'h42, 1'b1, -1});
    v.push_back(vec_t'{2'b01, 5'd1, 5'd0, 2'b00, 2'b00, 8'h00, 1'b1, 1});
    v.push_back(vec_t'{2'b00, 5'd1, 5'd0, 2'b00, 2'b01, 8'h42, 1'b1, 0});
    v.push_back(vec_t'{2'b00, 5'd1, 5'd0, 2'b00, 2'b00, 8'h00, 1'b0, 0});

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", gnt1, 0);
    chk("rst_rvalid", rvalid1, 0);
    chk("rst_rdata", rdata1, 0);
    chk("rst_rerror", rerror1, 0);
    chk("rst_maddr", maddr1, 0);
    chk("rst_bounds", {rlo1, rhi1}, 0);
    chk("rst_busy", busy1, 0);
    chk("rst_busy3", busy3, 0);
    reset = 0;

    foreach (v[i]) begin
      cyc_start();
      req = v[i].req; addr0 = v[i].a0; addr1 = v[i].a1;
      @(negedge clk);
      chk($sformatf("vec%0d_gnt", i), gnt1, v[i].gnt);
      chk($sformatf("vec%0d_rvalid", i), rvalid1, v[i].rv);
      chk($sformatf("vec%0d_busy", i), busy1, v[i].busy);
      if (v[i].rv != 0) begin
        chk($sformatf("vec%0d_rdata", i), rdata1[7:0], v[i].byt);
        chk($sformatf("vec%0d_rerror", i), rerror1, 0);
      end
      if (v[i].maddr >= 0) chk($sformatf("vec%0d_maddr", i), maddr1, 5'(v[i].maddr));
    end

    // bound violation on the data port, then a legal fetch at the same address
    repeat (4) cyc_start();
    cyc_start(); data_lo = 0; data_hi = 3; addr1 = 8; req = 2'b10;
    @(negedge clk); chk("bnd_gnt", gnt1, 2'b10);
    cyc_start(); req = 0; addr1 = 0;
    @(negedge clk);
    chk("bnd_lo", rlo1, 0); chk("bnd_hi", rhi1, 3); chk("bnd_maddr", maddr1, 8);
    cyc_start();
    @(negedge clk); chk("bnd_rvalid", rvalid1, 2'b10); chk("bnd_rerror", rerror1, 1);
    cyc_start(); data_hi = 31; code_lo = 0; code_hi = 31; addr0 = 8; req = 2'b01;
    @(negedge clk); chk("bnd2_gnt", gnt1, 2'b01);
    cyc_start(); req = 0;
    cyc_start();
    @(negedge clk);
    chk("bnd2_rvalid", rvalid1, 2'b01); chk("bnd2_rerror", rerror1, 0);
    chk("bnd2_rdata", rdata1[7:0], 8'h49);

    // asynchronous reset one cycle after a grant
    repeat (4) cyc_start();
    cyc_start(); addr0 = 7; req = 2'b01;
    @(negedge clk); chk("ar_gnt", gnt1, 2'b01);
    cyc_start(); req = 0;
    @(negedge clk); chk("ar_maddr_pre", maddr1, 7);
    #1 reset = 1;
    #1 chk("ar_maddr", maddr1, 0); chk("ar_busy", busy1, 0);
    repeat (2) cyc_start();
    reset = 0;
    for (int k = 0; k < 5; k++) begin
      cyc_start();
      @(negedge clk); chk($sformatf("ar_norv%0d", k), rvalid1, 0);
    end
    cyc_start(); addr1 = 4; req = 2'b10;
    @(negedge clk); chk("ar2_gnt", gnt1, 2'b10);
    cyc_start(); req = 0;
    cyc_start();
    @(negedge clk); chk("ar2_rvalid", rvalid1, 2'b10); chk("ar2_rdata", rdata1[7:0], 8'h45);

    // ROM_LAT=3 instance: held fetch request must not be granted during WAIT
    repeat (6) cyc_start();
    cyc_start(); addr1 = 6; req = 2'b10;
    @(negedge clk); chk("l3_gnt", gnt3, 2'b10);
    for (int k = 1; k <= 3; k++) begin
      cyc_start(); req = 2'b01; addr1 = 0;
      @(negedge clk);
      chk($sformatf("l3_nognt%0d", k), gnt3, 0);
      chk($sformatf("l3_maddr%0d", k), maddr3, 6);
      chk($sformatf("l3_norv%0d", k), rvalid3, 0);
    end
    cyc_start();
    @(negedge clk); chk("l3_rvalid", rvalid3, 2'b10); chk("l3_rdata", rdata3[7:0], 8'h47);
    cyc_start(); req = 0;
    repeat (6) cyc_start();

    // randomized run on the ROM_LAT=1 instance
    reset = 1;
    cyc_start();
    reset = 0;
    last_m = 1; pend = 0; pend_port = 0; pend_cyc = 0; gnt_cyc = 0; resp_cyc = 0;
    pend_data = 0; pend_err = 0;
    for (int n = 0; n < 406; n++) begin
      cyc_start();
      req = (n < 400) ? 2'($urandom_range(0, 3)) : 2'b00;
      addr0 = 5'($urandom); addr1 = 5'($urandom);
      extra0 = 4'($urandom_range(0, 3)); extra1 = 4'($urandom_range(0, 3));
      code_lo = 5'($urandom_range(0, 15)); code_hi = 5'($urandom_range(8, 31));
      data_lo = 5'($urandom_range(0, 15)); data_hi = 5'($urandom_range(8, 31));
      @(negedge clk);
      exp_rv = (pend && n == pend_cyc) ? (2'b01 << pend_port) : 2'b00;
      chk("rnd_rvalid", rvalid1, exp_rv);
      if (exp_rv != 0) begin
        chk("rnd_rdata", rdata1, pend_data);
        chk("rnd_rerror", rerror1, pend_err);
        pend = 0;
      end
      chk("rnd_busy", busy1, (n > gnt_cyc) && (n <= resp_cyc));
      exp_g = 0;
      if (n >= resp_cyc && req != 0) begin
        w = (req == 2'b11) ? int'(!last_m) : int'(req[1]);
        exp_g = 2'b01 << w;
        last_m = w[0]; pend = 1; pend_port = w[0];
        pend_cyc = n + 2; gnt_cyc = n; resp_cyc = n + 2;
        pend_data = w ? rom_read(addr1, extra1) : rom_read(addr0, extra0);
        pend_err  = w ? rom_err(addr1, extra1, data_lo, data_hi) : rom_err(addr0, extra0, code_lo, code_hi);
      end
      chk("rnd_gnt", gnt1, exp_g);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
